restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//  Sequential unsigned radix-2 restoring divider. It is the inverse datapath to the Dadda multiplier.
//  Produces quotient and remainder of dividend/divisor using one trial subtraction per clock.
//  Uses a start/ready/done handshake. Sits beside the multiplier in the arithmetic unit.
//  Its subtractor is built from full_adder cells.
// PARAMETERS
//  WIDTH  8  operand width in bits; quotient and remainder also WIDTH bits; legal range >= 2
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  start         in   1      request; accepted only on an edge where ready=1
//  dividend      in   WIDTH  unsigned dividend, sampled on the accepting edge
//  divisor       in   WIDTH  unsigned divisor, sampled on the accepting edge
//  ready         out  1      high only in IDLE
//  done          out  1      one-cycle pulse; results valid
//  quotient      out  WIDTH  registered result, held until next accepted start
//  remainder     out  WIDTH  registered result, held until next accepted start
//  div_by_zero   out  1      registered flag, updated with done, held like the results
// BEHAVIOUR
//  Reset (async assert, any cycle including mid-operation):
//   state=IDLE; ready=1; done=0; quotient=0; remainder=0; div_by_zero=0; internal regs cleared.
//  FSM states IDLE, LOAD_CALC (CALC), FINISH, DONE.
//   IDLE->CALC: on edge E with start=1. Capture operands; R=0 (WIDTH+1 bits); Q=dividend; cnt=WIDTH.
//   IDLE->FINISH: if the captured divisor==0, go to FINISH directly; no iterations run.
//  CALC: runs one iteration per edge, on edges E+1..E+WIDTH.
//   Rs = {R[WIDTH-1:0], Q[WIDTH-1]}; T = Rs - {1'b0,divisor}.
//   If T[WIDTH]==1 (negative): R=Rs and Q={Q[WIDTH-2:0],1'b0}.
//   Else: R=T and Q={Q[WIDTH-2:0],1'b1}.
//   cnt decrements each iteration; cnt==1 on an edge -> FINISH.
//  FINISH (one edge):
//   Write quotient=Q and remainder=R[WIDTH-1:0]; div_by_zero=0; done=1; go to DONE.
//   Divide-by-zero case: quotient={WIDTH{1'b1}}, remainder=captured dividend, div_by_zero=1.
//  DONE: done=1 for exactly this cycle; the next edge sets done=0 and returns to IDLE (ready=1).
//  Latency, normal case: start edge E; done visible after edge E+WIDTH+1; ready again after edge E+WIDTH+2.
//  Latency, divide-by-zero: done visible after edge E+1; ready again after edge E+2.
//  Inputs while busy: start while ready=0 is ignored. It is not queued and does not disturb the operation.
//   Operand changes while busy have no effect.
//  Back-to-back: a start held high is accepted on the first edge with ready=1.
//   Prior results stay stable until FINISH of the new operation.
//  All arithmetic is unsigned. Invariant: dividend == quotient*divisor + remainder, and remainder < divisor, when divisor!=0.
//  Reset mid-operation: the operation is abandoned; there is no partial-result visibility; the next start behaves as a fresh one.
// STRUCTURE
//  Package div_pkg:
//   enum state_t {IDLE, CALC, FINISH, DONE}
//   localparam for the counter width, $clog2(WIDTH+1)
//  Sub-module ripple_subtractor #(N=WIDTH+1):
//   N full_adder cells; b inverted; carry-in=1; outputs diff[N-1:0].
//   Combinational, instantiated once for T.
//  Top-level: FSM, cnt, R/Q shift registers, result/flag output registers.
// TESTING (WIDTH=8)
//  1 100/7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 9 edges after the start edge, high 1 cycle.
//  2 255/1 -> 255, 0; 5/9 -> 0, 5; 200/200 -> 1, 0; 0/13 -> 0, 0.
//  3 37/0 -> quotient=255, remainder=37, div_by_zero=1; done 1 edge after start; ready back after 2.
//  4 Pulse start mid-CALC with new operands (50/3) -> ignored; first result 100/7 is unchanged.
//    Held start then yields 16, 2 back-to-back.
//  5 Deassert rst_n at iteration 4 of 100/7 -> outputs 0, ready=1 immediately (async).
//    A fresh 9/2 after release -> 4, 1.
//  6 Random 2000 pairs including divisor=0 -> check the invariant or the div_by_zero rule, plus the latency, each time.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t CALC   = 2'd1;
    localparam state_t FINISH = 2'd2;
    localparam state_t DONE   = 2'd3;

    localparam int DIV_WIDTH = 8;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used by the ripple subtractor.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/ripple_subtractor.sv
// N-bit ripple subtractor: a - b computed as a + ~b + 1 through full_adder cells.
module ripple_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff
);

    logic [N:0] w_c;
    logic       w_unused_carry;

    assign w_c[0]         = 1'b1;
    assign w_unused_carry = w_c[N];

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (~i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_diff[i]),
            .o_c (w_c[i+1])
        );
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned radix-2 restoring divider, one trial subtraction per clock,
// with a start/ready/done handshake and registered quotient/remainder/div-by-zero.
//
// state  | meaning
// IDLE   | ready=1, waiting for start; operands captured on the accepting edge
// CALC   | one shift/trial-subtract iteration per edge, WIDTH edges total
// FINISH | write quotient/remainder/flag, raise done
// DONE   | done high for this single cycle, then back to IDLE
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_done;

    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_t;
    logic             w_unused_r_msb;

    assign w_rs           = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_unused_r_msb = r_r[WIDTH];

    ripple_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a    (w_rs),
        .i_b    ({1'b0, r_divisor}),
        .o_diff (w_t)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_r           <= '0;
            r_q           <= '0;
            r_divisor     <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_divisor <= i_divisor;
                        r_r       <= '0;
                        r_q       <= i_dividend;
                        r_cnt     <= CW'(WIDTH);
                        r_state   <= (i_divisor == '0) ? FINISH : CALC;
                    end
                end
                CALC: begin
                    if (w_t[WIDTH]) begin
                        r_r <= w_rs;
                        r_q <= {r_q[WIDTH-2:0], 1'b0};
                    end else begin
                        r_r <= w_t;
                        r_q <= {r_q[WIDTH-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    // With a zero divisor no iterations ran, so Q still holds the dividend.
                    if (r_divisor == '0) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_q;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= r_q;
                        r_remainder   <= r_r[WIDTH-1:0];
                        r_div_by_zero <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready       = (r_state == IDLE);
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=8): directed table, corner sequences, random.
module tb_restoring_divider;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_start;
    logic [7:0] i_dividend;
    logic [7:0] i_divisor;
    logic       o_ready;
    logic       o_done;
    logic [7:0] o_quotient;
    logic [7:0] o_remainder;
    logic       o_div_by_zero;

    int total = 0;
    int bad   = 0;

    restoring_divider #(.WIDTH(8)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_ready       (o_ready),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Starts one operation, checks latency, done pulse width and ready return; returns results.
    task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs, input int exp_lat,
                          input string tag, output logic [7:0] q, output logic [7:0] r,
                          output logic dz);
        int n;
        @(negedge i_clk);
        check($sformatf("%s ready_before", tag), o_ready, 1);
        i_start    = 1'b1;
        i_dividend = dvd;
        i_divisor  = dvs;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        n = 0;
        while (!o_done && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check($sformatf("%s latency", tag), n, exp_lat);
        check($sformatf("%s ready_low_in_done", tag), o_ready, 0);
        q  = o_quotient;
        r  = o_remainder;
        dz = o_div_by_zero;
        @(posedge i_clk);
        #1;
        check($sformatf("%s done_one_cycle", tag), o_done, 0);
        check($sformatf("%s ready_after", tag), o_ready, 1);
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] q, r;
        logic       dz;
        int         n;

        vecs[0] = '{dvd:8'd100, dvs:8'd7,   q:8'd14,  r:8'd2,  dz:1'b0, lat:9};
        vecs[1] = '{dvd:8'd255, dvs:8'd1,   q:8'd255, r:8'd0,  dz:1'b0, lat:9};
        vecs[2] = '{dvd:8'd5,   dvs:8'd9,   q:8'd0,   r:8'd5,  dz:1'b0, lat:9};
        vecs[3] = '{dvd:8'd200, dvs:8'd200, q:8'd1,   r:8'd0,  dz:1'b0, lat:9};
        vecs[4] = '{dvd:8'd0,   dvs:8'd13,  q:8'd0,   r:8'd0,  dz:1'b0, lat:9};
        vecs[5] = '{dvd:8'd37,  dvs:8'd0,   q:8'd255, r:8'd37, dz:1'b1, lat:1};
        vecs[6] = '{dvd:8'd255, dvs:8'd255, q:8'd1,   r:8'd0,  dz:1'b0, lat:9};

        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (2) @(negedge i_clk);
        check("reset ready", o_ready, 1);
        check("reset done", o_done, 0);
        check("reset quotient", o_quotient, 0);
        check("reset remainder", o_remainder, 0);
        check("reset dz", o_div_by_zero, 0);
        i_rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].lat, $sformatf("vec%0d", i), q, r, dz);
            check($sformatf("vec%0d quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d dz", i), dz, vecs[i].dz);
        end

        // Start pulsed mid-calculation must be ignored; held start then runs back-to-back.
        @(negedge i_clk);
        i_start = 1'b1; i_dividend = 8'd100; i_divisor = 8'd7;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_start = 1'b1; i_dividend = 8'd50; i_divisor = 8'd3;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        n = 3;
        while (!o_done && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("busy latency", n, 9);
        check("busy quotient", o_quotient, 14);
        check("busy remainder", o_remainder, 2);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        check("b2b done_low", o_done, 0);
        check("b2b ready_idle", o_ready, 1);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        check("b2b accepted", o_ready, 0);
        check("b2b prior_q_stable", o_quotient, 14);
        n = 0;
        while (!o_done && n < 40) begin
            @(posedge i_clk);
            #1;
            if (!o_done && n == 4) check("b2b prior_r_stable", o_remainder, 2);
            n++;
        end
        check("b2b latency", n, 9);
        check("b2b quotient", o_quotient, 16);
        check("b2b remainder", o_remainder, 2);
        repeat (2) @(posedge i_clk);

        // Asynchronous reset during iteration 4 of 100/7.
        @(negedge i_clk);
        i_start = 1'b1; i_dividend = 8'd100; i_divisor = 8'd7;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst ready", o_ready, 1);
        check("midrst done", o_done, 0);
        check("midrst quotient", o_quotient, 0);
        check("midrst remainder", o_remainder, 0);
        check("midrst dz", o_div_by_zero, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op(8'd9, 8'd2, 9, "postrst", q, r, dz);
        check("postrst quotient", q, 4);
        check("postrst remainder", r, 1);
        check("postrst dz", dz, 0);

        // Random operands against plain integer division and the division invariant.
        for (int k = 0; k < 2000; k++) begin
            logic [7:0] dvd, dvs;
            int         exp_q, exp_r;
            dvd = 8'($urandom_range(0, 255));
            dvs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            exp_q = (dvs == 0) ? 255 : int'(dvd) / int'(dvs);
            exp_r = (dvs == 0) ? int'(dvd) : int'(dvd) % int'(dvs);
            run_op(dvd, dvs, (dvs == 0) ? 1 : 9, $sformatf("rnd%0d", k), q, r, dz);
            check($sformatf("rnd%0d quotient %0d/%0d", k, dvd, dvs), q, exp_q);
            check($sformatf("rnd%0d remainder %0d/%0d", k, dvd, dvs), r, exp_r);
            check($sformatf("rnd%0d dz", k), dz, (dvs == 0));
            if (dvs != 0) begin
                check($sformatf("rnd%0d invariant", k), int'(q) * int'(dvs) + int'(r), int'(dvd));
                check($sformatf("rnd%0d rem_lt_div", k), (r < dvs), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
